// File: rtl/adc_frame_sched.sv
// ADC frame scheduler: decimates DRDY pulses, launches SPI frame reads, and publishes completed frames.
// Flags DRDY overruns and capture timeouts.
module adc_frame_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             drdy_fall_pulse,
  input  logic [7:0]       decim,
  input  logic             spi_done,
  input  logic             status_clear,
  output logic             spi_start,
  output logic             frame_valid,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy,
  output logic             overrun,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_START   = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  localparam logic [15:0] TMR_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  dcnt;
  logic [15:0] tmr;

  logic in_flight;
  logic accept;
  logic hit;
  logic done_evt;
  logic tmo_evt;
  logic ovr_evt;

  always_comb begin
    in_flight = (state == S_START) || (state == S_CAPTURE);
    accept    = (state == S_WAIT) && enable && drdy_fall_pulse;
    // Equality only: a lowered decim lets dcnt run on and wrap through 255.
    hit       = accept && (dcnt == decim);
    done_evt  = (state == S_CAPTURE) && spi_done;
    tmo_evt   = (state == S_CAPTURE) && !spi_done && (tmr == TMR_LAST);
    ovr_evt   = in_flight && drdy_fall_pulse;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!enable)  state_nxt = S_IDLE;
        else if (hit) state_nxt = S_START;
      end
      S_START: begin
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (done_evt || tmo_evt) state_nxt = enable ? S_WAIT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    spi_start = (state == S_START);
    busy      = in_flight;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt        <= 8'd0;
      tmr         <= 16'd0;
      frame_cnt   <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      frame_valid <= done_evt;
      if (done_evt) frame_cnt <= frame_cnt + CNT_W'(1);

      if (state == S_IDLE) begin
        dcnt <= 8'd0;
      end else if (state == S_WAIT) begin
        if (!enable)     dcnt <= 8'd0;
        else if (hit)    dcnt <= 8'd0;
        else if (accept) dcnt <= dcnt + 8'd1;
      end

      if (state == S_START) begin
        tmr <= 16'd0;
      end else if ((state == S_CAPTURE) && !spi_done) begin
        tmr <= tmr + 16'd1;
      end

      // A set event in the same cycle as status_clear keeps the flag high.
      if (ovr_evt)           overrun <= 1'b1;
      else if (status_clear) overrun <= 1'b0;

      if (tmo_evt)           timeout <= 1'b1;
      else if (status_clear) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_frame_sched.sv
// Directed bench for adc_frame_sched: one instance with a long timeout for the
// capture scenarios and one with TIMEOUT_CYCLES=8 for the timeout scenario.
module tb_adc_frame_sched;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       drdy_fall_pulse;
  logic [7:0] decim;
  logic       spi_done;
  logic       status_clear;

  logic       m_spi_start, m_frame_valid, m_busy, m_overrun, m_timeout;
  logic [3:0] m_frame_cnt;
  logic       t_spi_start, t_frame_valid, t_busy, t_overrun, t_timeout;
  logic [3:0] t_frame_cnt;

  int checks = 0;
  int errors = 0;

  adc_frame_sched #(.TIMEOUT_CYCLES(64), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .drdy_fall_pulse(drdy_fall_pulse),
    .decim(decim), .spi_done(spi_done), .status_clear(status_clear),
    .spi_start(m_spi_start), .frame_valid(m_frame_valid), .frame_cnt(m_frame_cnt),
    .busy(m_busy), .overrun(m_overrun), .timeout(m_timeout)
  );

  adc_frame_sched #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut_t (
    .clk(clk), .rst(rst), .enable(enable), .drdy_fall_pulse(drdy_fall_pulse),
    .decim(decim), .spi_done(spi_done), .status_clear(status_clear),
    .spi_start(t_spi_start), .frame_valid(t_frame_valid), .frame_cnt(t_frame_cnt),
    .busy(t_busy), .overrun(t_overrun), .timeout(t_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are observed 1ns after the edge and pulses drop.
  task automatic tick();
    @(posedge clk);
    #1;
    drdy_fall_pulse = 1'b0;
    spi_done        = 1'b0;
    status_clear    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; decim = 8'd0;
    drdy_fall_pulse = 1'b1; spi_done = 1'b1; status_clear = 1'b0;
    tick();
    drdy_fall_pulse = 1'b1;
    tick();
    checks++;
    if ({m_spi_start, m_frame_valid, m_busy, m_overrun, m_timeout, m_frame_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000000",
               {m_spi_start, m_frame_valid, m_busy, m_overrun, m_timeout, m_frame_cnt});
    end
    checks++;
    if ({t_spi_start, t_frame_valid, t_busy, t_overrun, t_timeout, t_frame_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs_t: got %b expected 000000000",
               {t_spi_start, t_frame_valid, t_busy, t_overrun, t_timeout, t_frame_cnt});
    end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    do_reset();
    enable = 1'b1; decim = 8'd0;
    tick();
    drdy_fall_pulse = 1'b1;   // cycle T
    tick();                   // T+1
    checks++;
    if (m_spi_start !== 1'b1 || m_busy !== 1'b1) begin
      errors++;
      $display("FAIL normal_start: spi_start=%b busy=%b expected 1 1", m_spi_start, m_busy);
    end
    for (int i = 2; i <= 10; i++) begin
      tick();                 // T+i
      checks++;
      if (m_spi_start !== 1'b0 || m_busy !== 1'b1 || m_frame_valid !== 1'b0) begin
        errors++;
        $display("FAIL normal_capture_T+%0d: spi_start=%b busy=%b frame_valid=%b expected 0 1 0",
                 i, m_spi_start, m_busy, m_frame_valid);
      end
      if (i == 10) spi_done = 1'b1;
    end
    tick();                   // T+11
    checks++;
    if (m_frame_valid !== 1'b1 || m_frame_cnt !== 4'd1 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL normal_publish: frame_valid=%b frame_cnt=%0d busy=%b expected 1 1 0",
               m_frame_valid, m_frame_cnt, m_busy);
    end
    tick();
    checks++;
    if (m_frame_valid !== 1'b0 || m_frame_cnt !== 4'd1) begin
      errors++;
      $display("FAIL normal_after: frame_valid=%b frame_cnt=%0d expected 0 1", m_frame_valid, m_frame_cnt);
    end
  endtask

  task automatic test_decim();
    int starts;
    starts = 0;
    do_reset();
    enable = 1'b1; decim = 8'd2;
    tick();
    for (int p = 0; p < 6; p++) begin
      drdy_fall_pulse = 1'b1;
      tick();
      checks++;
      if (m_spi_start !== ((p % 3) == 2)) begin
        errors++;
        $display("FAIL decim_pulse%0d: spi_start=%b expected %0d", p, m_spi_start, (p % 3) == 2);
      end
      if (m_spi_start === 1'b1) begin
        starts++;
        for (int k = 0; k < 4; k++) tick();
        tick();
        spi_done = 1'b1;
        tick();
      end
      tick();
    end
    checks++;
    if (starts != 2 || m_frame_cnt !== 4'd2 || m_overrun !== 1'b0) begin
      errors++;
      $display("FAIL decim_totals: starts=%0d frame_cnt=%0d overrun=%b expected 2 2 0",
               starts, m_frame_cnt, m_overrun);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    enable = 1'b1; decim = 8'd0;
    tick();
    drdy_fall_pulse = 1'b1;
    tick();                   // START
    tick();                   // CAPTURE
    drdy_fall_pulse = 1'b1;
    tick();
    checks++;
    if (m_overrun !== 1'b1 || m_spi_start !== 1'b0) begin
      errors++;
      $display("FAIL overrun_capture: overrun=%b spi_start=%b expected 1 0", m_overrun, m_spi_start);
    end
    tick();
    spi_done = 1'b1; drdy_fall_pulse = 1'b1;
    tick();
    checks++;
    if (m_frame_valid !== 1'b1 || m_frame_cnt !== 4'd1 || m_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_done: frame_valid=%b frame_cnt=%0d overrun=%b expected 1 1 1",
               m_frame_valid, m_frame_cnt, m_overrun);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_spi_start !== 1'b0) begin
        errors++;
        $display("FAIL overrun_no_start%0d: spi_start=%b expected 0", i, m_spi_start);
      end
      tick();
    end
    checks++;
    if (m_frame_cnt !== 4'd1) begin
      errors++;
      $display("FAIL overrun_cnt: frame_cnt=%0d expected 1", m_frame_cnt);
    end
    status_clear = 1'b1;
    tick();
    checks++;
    if (m_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: overrun=%b expected 0", m_overrun);
    end
    drdy_fall_pulse = 1'b1;
    tick();                   // START
    status_clear = 1'b1; drdy_fall_pulse = 1'b1;
    tick();
    checks++;
    if (m_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins: overrun=%b expected 1", m_overrun);
    end
    spi_done = 1'b1;
    tick();
    checks++;
    if (m_frame_cnt !== 4'd2) begin
      errors++;
      $display("FAIL overrun_cnt2: frame_cnt=%0d expected 2", m_frame_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    enable = 1'b1; decim = 8'd0;
    tick();
    drdy_fall_pulse = 1'b1;
    tick();                   // S
    checks++;
    if (t_spi_start !== 1'b1) begin
      errors++;
      $display("FAIL timeout_start: spi_start=%b expected 1", t_spi_start);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();                 // S+k, tmr = k-1
      checks++;
      if (t_busy !== 1'b1 || t_timeout !== 1'b0 || t_frame_valid !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait_S+%0d: busy=%b timeout=%b frame_valid=%b expected 1 0 0",
                 k, t_busy, t_timeout, t_frame_valid);
      end
    end
    tick();                   // S+9
    checks++;
    if (t_timeout !== 1'b1 || t_busy !== 1'b0 || t_frame_valid !== 1'b0 || t_frame_cnt !== 4'd0) begin
      errors++;
      $display("FAIL timeout_fire: timeout=%b busy=%b frame_valid=%b frame_cnt=%0d expected 1 0 0 0",
               t_timeout, t_busy, t_frame_valid, t_frame_cnt);
    end
    drdy_fall_pulse = 1'b1;
    tick();
    checks++;
    if (t_spi_start !== 1'b1 || t_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_restart: spi_start=%b timeout=%b expected 1 1", t_spi_start, t_timeout);
    end
    status_clear = 1'b1;
    tick();
    checks++;
    if (t_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: timeout=%b expected 0", t_timeout);
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    enable = 1'b1; decim = 8'd0;
    tick();
    drdy_fall_pulse = 1'b1;
    tick();                   // START
    tick();                   // CAPTURE
    enable = 1'b0;
    tick();
    tick();
    checks++;
    if (m_busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_still_busy: busy=%b expected 1", m_busy);
    end
    spi_done = 1'b1;
    tick();
    checks++;
    if (m_frame_valid !== 1'b1 || m_busy !== 1'b0 || m_frame_cnt !== 4'd1) begin
      errors++;
      $display("FAIL drop_publish: frame_valid=%b busy=%b frame_cnt=%0d expected 1 0 1",
               m_frame_valid, m_busy, m_frame_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      drdy_fall_pulse = 1'b1;
      spi_done = 1'b1;
      tick();
      checks++;
      if (m_spi_start !== 1'b0 || m_frame_valid !== 1'b0) begin
        errors++;
        $display("FAIL drop_idle%0d: spi_start=%b frame_valid=%b expected 0 0", i, m_spi_start, m_frame_valid);
      end
    end
  endtask

  task automatic test_decim_wrap();
    int early;
    early = 0;
    do_reset();
    enable = 1'b1; decim = 8'd5;
    tick();
    for (int p = 0; p < 3; p++) begin
      drdy_fall_pulse = 1'b1;
      tick();
    end
    decim = 8'd1;             // dcnt is now 3, above decim
    for (int p = 0; p < 254; p++) begin
      drdy_fall_pulse = 1'b1;
      tick();
      if (m_spi_start === 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL wrap_no_early_start: starts=%0d expected 0", early);
    end
    drdy_fall_pulse = 1'b1;
    tick();
    checks++;
    if (m_spi_start !== 1'b1) begin
      errors++;
      $display("FAIL wrap_start: spi_start=%b expected 1", m_spi_start);
    end
  endtask

  task automatic test_reset_mid_capture();
    do_reset();
    enable = 1'b1; decim = 8'd0;
    tick();
    drdy_fall_pulse = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1; spi_done = 1'b1; drdy_fall_pulse = 1'b1; status_clear = 1'b0;
    tick();
    checks++;
    if ({m_spi_start, m_frame_valid, m_busy, m_overrun, m_timeout, m_frame_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b expected 000000000",
               {m_spi_start, m_frame_valid, m_busy, m_overrun, m_timeout, m_frame_cnt});
    end
    rst = 1'b0;
    spi_done = 1'b1;
    tick();
    checks++;
    if (m_frame_valid !== 1'b0 || m_frame_cnt !== 4'd0 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_late_done: frame_valid=%b frame_cnt=%0d busy=%b expected 0 0 0",
               m_frame_valid, m_frame_cnt, m_busy);
    end
    for (int n = 1; n <= 16; n++) begin
      drdy_fall_pulse = 1'b1;
      tick();
      tick();
      spi_done = 1'b1;
      tick();
      checks++;
      if (m_frame_valid !== 1'b1 || m_frame_cnt !== 4'(n)) begin
        errors++;
        $display("FAIL wrap_frame%0d: frame_valid=%b frame_cnt=%0d expected 1 %0d",
                 n, m_frame_valid, m_frame_cnt, n % 16);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; drdy_fall_pulse = 1'b0;
    decim = 8'd0; spi_done = 1'b0; status_clear = 1'b0;
    test_reset();
    test_normal();
    test_decim();
    test_overrun();
    test_timeout();
    test_enable_drop();
    test_decim_wrap();
    test_reset_mid_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
